fp_normalize: RTL and testbench
===============================

# fp_normalize

Iterative post-add normaliser for the 32-bit floating-point ALU. It sits directly downstream of the 24-bit mantissa carry-lookahead adder. It accepts the raw 24-bit sum and carry/overflow bit with the pre-alignment exponent and sign, then renormalises the mantissa:
- right shift on carry-out,
- left shift one bit per cycle until the hidden bit is set.

It emits a packed IEEE-754 single-precision word with zero/overflow/underflow flags over a valid/ready handshake.

## Interface
Parameters: none. Widths are fixed to single precision: 8-bit exponent, 24-bit mantissa including the hidden bit.

- CLK  in  1  single clock; all state on rising edge
- RST_N  in  1  asynchronous, active-low reset
- IN_VALID  in  1  input operands valid
- IN_READY  out  1  block can accept; high exactly when state is IDLE
- SIGN  in  1  sign of result from the sign/compare stage
- EXP  in  8  common (larger) biased exponent after alignment
- MANT  in  24  adder sum output
- OF  in  1  adder carry-out
- SUB  in  1  adder was run with its carry-in set (effective subtraction); when 1, OF is a no-borrow indicator and is ignored
- OUT_VALID  out  1  RESULT and flags valid
- OUT_READY  in  1  downstream accepts result
- RESULT  out  32  {sign, exponent[7:0], fraction[22:0]}
- ZERO  out  1  result is zero (exact or flushed)
- OVF  out  1  exponent overflow; RESULT is ±infinity
- UNF  out  1  exponent underflow; RESULT flushed to signed zero

## Operation
- **States:** IDLE, NORM, DONE. Internal registers: s, e[7:0], m[23:0].
- **Accept** on a rising edge with IN_VALID && IN_READY. Capture s=SIGN, e=EXP, m=MANT, then branch:
  - **Carry** (SUB==0 && OF==1):
    - If EXP>=254: go to DONE with OVF=1, RESULT={SIGN,8'hFF,23'h0}.
    - Otherwise m={1'b1,MANT[23:1]}, e=EXP+1, go to NORM. The LSB is truncated; there is no rounding.
  - **Zero** (MANT==0, and not the carry case): go to DONE with ZERO=1, RESULT=32'h00000000. Sign is forced to 0.
  - **Otherwise:** go to NORM.
- **NORM**, evaluated once per cycle, in priority order:
  1. If m[23]==1: go to DONE with RESULT={s,e,m[22:0]}.
  2. Else if e<=1: go to DONE with UNF=1, ZERO=1, RESULT={s,31'h0}.
  3. Else: m<=m<<1, e<=e-1, stay in NORM.
- **DONE:** OUT_VALID=1. RESULT and flags are held stable until OUT_READY. On OUT_VALID && OUT_READY, go to IDLE. OUT_VALID and all flags clear on that edge.
- **Flags:** at most one of OVF/UNF is set. ZERO is also set with UNF.
- **Subnormals:** none produced; they flush to zero. Exponent input 255 without carry passes through as a normal value (NaN/Inf handling is upstream).
- **Outputs:** all registered. IN_READY is decoded from the state register only, with no combinational path from any input.

## Timing
- **Reset:** RST_N low → state IDLE and s, e, m, RESULT, OUT_VALID, ZERO, OVF and UNF all 0, all asynchronously. IN_READY is 1 during and after reset.
- **Latency:** accept edge is cycle 0.
  - Zero and overflow cases: OUT_VALID at cycle 1.
  - NORM path with k leading zeros in m after capture (0..23): OUT_VALID at cycle 2+k. Maximum is 25.
  - Underflow terminates earlier, when e reaches 1.
- **Throughput:** one operation in flight. IN_READY is low from the cycle after accept until the cycle after the DONE handshake. There is no accept on the same edge as the output handshake.
- **Back-pressure:** OUT_VALID held indefinitely while OUT_READY is low. Input changes are ignored outside IDLE.
- **Reset mid-operation:** in-flight data is discarded. There is no output pulse. The next accept is possible on the first edge after RST_N deasserts.

## Test plan
- Carry: SUB=0, SIGN=0, EXP=8'h80, MANT=24'h800000, OF=1 → cycle 2: OUT_VALID=1, RESULT=32'h40C00000, all flags 0.
- Cancellation: SUB=1, OF=1, SIGN=0, EXP=8'h80, MANT=24'h000100 → 15 shifts. Cycle 17: RESULT=32'h38800000, flags 0. IN_READY=0 for cycles 1–17.
- Exact zero: SUB=1, SIGN=1, EXP=8'h45, MANT=0 → cycle 1: RESULT=32'h00000000, ZERO=1.
- Overflow: SUB=0, SIGN=0, EXP=8'hFE, MANT=24'hFFFFFF, OF=1 → cycle 1: RESULT=32'h7F800000, OVF=1.
- Underflow: SUB=1, SIGN=1, EXP=8'h03, MANT=24'h000001 → cycle 4: RESULT=32'h80000000, UNF=1, ZERO=1.
- Handshake/reset:
  - Run the carry case with OUT_READY=0 for 5 cycles → RESULT held and IN_READY=0 throughout. Raising OUT_READY gives IN_READY=1 on the next cycle.
  - Separately, pulse RST_N low during NORM → OUT_VALID never asserts. After release, a fresh carry operation returns 32'h40C00000 at cycle 2.

Source files
------------

// File: rtl/fp_normalize.sv
// Post-add normaliser for single-precision floats: corrects adder carry-out, then
// left-shifts one bit per cycle until the hidden bit is set, emitting a packed word.
module fp_normalize (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        IN_VALID,
    output logic        IN_READY,
    input  logic        SIGN,
    input  logic [7:0]  EXP,
    input  logic [23:0] MANT,
    input  logic        OF,
    input  logic        SUB,
    output logic        OUT_VALID,
    input  logic        OUT_READY,
    output logic [31:0] RESULT,
    output logic        ZERO,
    output logic        OVF,
    output logic        UNF
);

    typedef enum logic [1:0] {IDLE, NORM, DONE} state_t;

    state_t      state_q;
    logic        s_q;
    logic [7:0]  e_q;
    logic [23:0] m_q;
    logic [31:0] result_q;
    logic        out_valid_q, zero_q, ovf_q, unf_q;

    logic        carry_d;
    logic [23:0] m_car_d, m_shl_d;
    logic [7:0]  e_inc_d, e_dec_d;

    function automatic logic [31:0] pack_fp(input logic s, input logic [7:0] e,
                                            input logic [22:0] f);
        return {s, e, f};
    endfunction

    function automatic logic [31:0] sat_inf(input logic s);
        return {s, 8'hFF, 23'h0};
    endfunction

    // With SUB set the carry-out only means "no borrow", so it never renormalises right.
    always_comb begin
        carry_d = !SUB && OF;
        m_car_d = {1'b1, MANT[23:1]};
        e_inc_d = EXP + 8'd1;
        m_shl_d = {m_q[22:0], 1'b0};
        e_dec_d = e_q - 8'd1;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q     <= IDLE;
            s_q         <= 1'b0;
            e_q         <= 8'h00;
            m_q         <= 24'h0;
            result_q    <= 32'h0;
            out_valid_q <= 1'b0;
            zero_q      <= 1'b0;
            ovf_q       <= 1'b0;
            unf_q       <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (IN_VALID) begin
                        s_q <= SIGN;
                        e_q <= EXP;
                        m_q <= MANT;
                        if (carry_d) begin
                            if (EXP >= 8'd254) begin
                                result_q    <= sat_inf(SIGN);
                                ovf_q       <= 1'b1;
                                out_valid_q <= 1'b1;
                                state_q     <= DONE;
                            end else begin
                                m_q     <= m_car_d;
                                e_q     <= e_inc_d;
                                state_q <= NORM;
                            end
                        end else if (MANT == 24'h0) begin
                            s_q         <= 1'b0;
                            result_q    <= 32'h0;
                            zero_q      <= 1'b1;
                            out_valid_q <= 1'b1;
                            state_q     <= DONE;
                        end else begin
                            state_q <= NORM;
                        end
                    end
                end
                NORM: begin
                    if (m_q[23]) begin
                        result_q    <= pack_fp(s_q, e_q, m_q[22:0]);
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end else if (e_q <= 8'd1) begin
                        // No subnormal output: flush to signed zero.
                        result_q    <= {s_q, 31'h0};
                        unf_q       <= 1'b1;
                        zero_q      <= 1'b1;
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end else begin
                        m_q <= m_shl_d;
                        e_q <= e_dec_d;
                    end
                end
                DONE: begin
                    if (OUT_READY) begin
                        out_valid_q <= 1'b0;
                        zero_q      <= 1'b0;
                        ovf_q       <= 1'b0;
                        unf_q       <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign IN_READY  = (state_q == IDLE);
    assign OUT_VALID = out_valid_q;
    assign RESULT    = result_q;
    assign ZERO      = zero_q;
    assign OVF       = ovf_q;
    assign UNF       = unf_q;

endmodule

// File: tb/tb_fp_normalize.sv
// Directed bench for fp_normalize: carry, cancellation, zero, overflow, underflow,
// exponent boundaries, back-pressure and mid-operation reset.
module tb_fp_normalize;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic        IN_VALID;
    logic        IN_READY;
    logic        SIGN;
    logic [7:0]  EXP;
    logic [23:0] MANT;
    logic        OF;
    logic        SUB;
    logic        OUT_VALID;
    logic        OUT_READY;
    logic [31:0] RESULT;
    logic        ZERO, OVF, UNF;

    int total  = 0;
    int passed = 0;

    fp_normalize dut (
        .CLK(CLK), .RST_N(RST_N), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
        .SIGN(SIGN), .EXP(EXP), .MANT(MANT), .OF(OF), .SUB(SUB),
        .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .RESULT(RESULT),
        .ZERO(ZERO), .OVF(OVF), .UNF(UNF)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total++;
        assert (obs === exp_v) passed++;
        else begin
            $display("FAIL %s: observed %h expected %h", tag, obs, exp_v);
            $error("check %s", tag);
        end
    endtask

    // Present an operation and return just after the accept edge (cycle 0).
    task automatic start(input logic sg, input logic [7:0] ex, input logic [23:0] mn,
                         input logic of, input logic sb);
        @(negedge CLK);
        SIGN = sg; EXP = ex; MANT = mn; OF = of; SUB = sb; IN_VALID = 1'b1;
        @(posedge CLK);
        #1;
        IN_VALID = 1'b0;
        SIGN = ~sg; EXP = 8'h5A; MANT = 24'hA5A5A5; OF = ~of; SUB = ~sb;
    endtask

    // Check busy/idle cycles up to the result cycle, the result, then return to idle.
    task automatic finish(input string tag, input int lat, input logic [31:0] res,
                          input logic z, input logic o, input logic u);
        for (int c = 1; c < lat; c++) begin
            @(negedge CLK);
            chk({tag, "_early_vld"}, {31'h0, OUT_VALID}, 32'h0);
            chk({tag, "_busy"}, {31'h0, IN_READY}, 32'h0);
        end
        @(negedge CLK);
        chk({tag, "_vld"}, {31'h0, OUT_VALID}, 32'h1);
        chk({tag, "_rdy_in_done"}, {31'h0, IN_READY}, 32'h0);
        chk({tag, "_result"}, RESULT, res);
        chk({tag, "_zero"}, {31'h0, ZERO}, {31'h0, z});
        chk({tag, "_ovf"}, {31'h0, OVF}, {31'h0, o});
        chk({tag, "_unf"}, {31'h0, UNF}, {31'h0, u});
        @(negedge CLK);
        chk({tag, "_vld_clr"}, {31'h0, OUT_VALID}, 32'h0);
        chk({tag, "_rdy_back"}, {31'h0, IN_READY}, 32'h1);
        chk({tag, "_flags_clr"}, {29'h0, ZERO, OVF, UNF}, 32'h0);
    endtask

    initial begin
        int seen;
        RST_N = 1'b0; IN_VALID = 1'b0; SIGN = 1'b0; EXP = 8'h0; MANT = 24'h0;
        OF = 1'b0; SUB = 1'b0; OUT_READY = 1'b1;

        #2;
        chk("rst_in_ready", {31'h0, IN_READY}, 32'h1);
        chk("rst_out_valid", {31'h0, OUT_VALID}, 32'h0);
        chk("rst_result", RESULT, 32'h0);
        chk("rst_flags", {29'h0, ZERO, OVF, UNF}, 32'h0);
        repeat (2) @(negedge CLK);
        RST_N = 1'b1;

        // 1.0 * 2^1 + carry: 0x800000 + carry -> 0xC00000, exp 0x81
        start(1'b0, 8'h80, 24'h800000, 1'b1, 1'b0);
        finish("carry", 2, 32'h40C00000, 1'b0, 1'b0, 1'b0);

        start(1'b0, 8'h80, 24'h000100, 1'b1, 1'b1);
        finish("cancel", 17, 32'h38800000, 1'b0, 1'b0, 1'b0);

        start(1'b1, 8'h45, 24'h000000, 1'b0, 1'b1);
        finish("zero", 1, 32'h00000000, 1'b1, 1'b0, 1'b0);

        start(1'b0, 8'hFE, 24'hFFFFFF, 1'b1, 1'b0);
        finish("ovf", 1, 32'h7F800000, 1'b0, 1'b1, 1'b0);

        start(1'b1, 8'h03, 24'h000001, 1'b0, 1'b1);
        finish("unf", 4, 32'h80000000, 1'b1, 1'b0, 1'b1);

        // Carry just below overflow lands on exponent 254 without saturating.
        start(1'b1, 8'hFD, 24'hFFFFFF, 1'b1, 1'b0);
        finish("carry_253", 2, 32'hFF7FFFFF, 1'b0, 1'b0, 1'b0);

        // Exponent 255 without carry is passed straight through.
        start(1'b0, 8'hFF, 24'h800000, 1'b1, 1'b1);
        finish("exp_255", 2, 32'h7F800000, 1'b0, 1'b0, 1'b0);

        // Back-pressure: result held for 5 cycles, new inputs ignored meanwhile.
        OUT_READY = 1'b0;
        start(1'b0, 8'h80, 24'h800000, 1'b1, 1'b0);
        @(negedge CLK);
        chk("bp_early_vld", {31'h0, OUT_VALID}, 32'h0);
        SIGN = 1'b1; EXP = 8'h10; MANT = 24'h000000; OF = 1'b0; SUB = 1'b1; IN_VALID = 1'b1;
        for (int c = 2; c <= 6; c++) begin
            @(negedge CLK);
            chk("bp_vld", {31'h0, OUT_VALID}, 32'h1);
            chk("bp_result", RESULT, 32'h40C00000);
            chk("bp_in_ready", {31'h0, IN_READY}, 32'h0);
        end
        OUT_READY = 1'b1;
        IN_VALID = 1'b0;
        @(negedge CLK);
        chk("bp_rdy_back", {31'h0, IN_READY}, 32'h1);
        chk("bp_vld_clr", {31'h0, OUT_VALID}, 32'h0);

        // Reset during NORM discards the operation.
        start(1'b0, 8'h80, 24'h000100, 1'b1, 1'b1);
        repeat (3) @(negedge CLK);
        RST_N = 1'b0;
        #1;
        chk("mid_rst_in_ready", {31'h0, IN_READY}, 32'h1);
        chk("mid_rst_vld", {31'h0, OUT_VALID}, 32'h0);
        seen = 0;
        repeat (3) begin
            @(negedge CLK);
            if (OUT_VALID !== 1'b0) seen++;
        end
        chk("mid_rst_hold_vld", seen, 0);
        // Accept on the very first edge after release.
        RST_N = 1'b1;
        SIGN = 1'b0; EXP = 8'h80; MANT = 24'h800000; OF = 1'b1; SUB = 1'b0; IN_VALID = 1'b1;
        @(posedge CLK);
        #1;
        IN_VALID = 1'b0;
        finish("post_rst", 2, 32'h40C00000, 1'b0, 1'b0, 1'b0);
        seen = 0;
        repeat (20) begin
            @(negedge CLK);
            if (OUT_VALID !== 1'b0) seen++;
        end
        chk("post_rst_no_pulse", seen, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
